mem_cmd_splitter: RTL

MEM_CMD_SPLITTER -- requirements
Module: mem_cmd_splitter

---
 rtl/mem_cmd_splitter_pkg.sv | 25 ++
 rtl/mem_cmd_splitter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_cmd_splitter_pkg.sv
// ============================================================================
// mem_cmd_splitter_pkg : shared command type, page constant and FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_cmd_splitter_pkg;

  localparam int unsigned c_PAGE_BYTES = 4096;
  localparam int unsigned c_ADDR_W     = 64;
  localparam int unsigned c_LEN_W      = 32;

  typedef struct packed {
    logic [c_ADDR_W-1:0] address;
    logic [c_LEN_W-1:0]  length;
  } mem_cmd_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_cmd_splitter.sv
// ============================================================================
// mem_cmd_splitter : splits (address, length) commands into MAX_BURST-aligned
// chunks. Optional handshake counters via MEM_CMD_SPLITTER_STATS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_cmd_splitter
  import mem_cmd_splitter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned LEN_W     = 32,
  parameter int unsigned MAX_BURST = 4096
) (
  input  logic              user_clk,
  input  logic              user_areset,
  input  logic              s_axis_cmd_valid,
  output logic              s_axis_cmd_ready,
  input  logic [ADDR_W-1:0] s_axis_cmd_address,
  input  logic [LEN_W-1:0]  s_axis_cmd_length,
  output logic              m_axis_cmd_valid,
  input  logic              m_axis_cmd_ready,
  output logic [ADDR_W-1:0] m_axis_cmd_address,
  output logic [LEN_W-1:0]  m_axis_cmd_length,
  output logic              m_axis_cmd_last
`ifdef MEM_CMD_SPLITTER_STATS_EN
  ,
  output logic [31:0]       stat_in_cmds,
  output logic [31:0]       stat_out_cmds
`endif
);

  localparam int unsigned c_BURST   = (MAX_BURST > c_PAGE_BYTES) ? c_PAGE_BYTES : MAX_BURST;
  localparam int unsigned c_OFF_W   = $clog2(c_BURST);
  localparam logic [LEN_W:0] c_BURST_W = (LEN_W+1)'(c_BURST);

  split_state_t      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cur_addr, w_cur_addr_nxt;
  logic [LEN_W-1:0]  r_remaining, w_remaining_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_m_valid, w_m_valid_nxt;
  logic [ADDR_W-1:0] r_m_addr, w_m_addr_nxt;
  logic [LEN_W-1:0]  r_m_len, w_m_len_nxt;
  logic              r_m_last, w_m_last_nxt;

  logic [ADDR_W-1:0] w_base_addr;
  logic [LEN_W-1:0]  w_base_rem;
  logic [LEN_W:0]    w_room;
  logic [LEN_W-1:0]  w_chunk;
  logic              w_in_hs, w_out_hs, w_load;

  assign w_in_hs  = s_axis_cmd_valid && r_ready;
  assign w_out_hs = r_m_valid && m_axis_cmd_ready;

  // r_cur_addr/r_remaining always describe what follows the chunk on the outputs.
  always_comb begin
    w_base_addr = (r_state == ST_IDLE) ? s_axis_cmd_address : r_cur_addr;
    w_base_rem  = (r_state == ST_IDLE) ? s_axis_cmd_length  : r_remaining;
    w_room      = c_BURST_W - (LEN_W+1)'(w_base_addr[c_OFF_W-1:0]);
    w_chunk     = ({1'b0, w_base_rem} < w_room) ? w_base_rem : w_room[LEN_W-1:0];
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_load          = 1'b0;
    w_cur_addr_nxt  = r_cur_addr;
    w_remaining_nxt = r_remaining;
    w_m_valid_nxt   = r_m_valid;
    w_m_addr_nxt    = r_m_addr;
    w_m_len_nxt     = r_m_len;
    w_m_last_nxt    = r_m_last;

    case (r_state)
      ST_IDLE: begin
        if (w_in_hs && (s_axis_cmd_length != '0)) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SPLIT;
        end
      end
      ST_SPLIT: begin
        if (w_out_hs) begin
          if (r_m_last) begin
            w_m_valid_nxt = 1'b0;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_load) begin
      w_m_valid_nxt   = 1'b1;
      w_m_addr_nxt    = w_base_addr;
      w_m_len_nxt     = w_chunk;
      w_m_last_nxt    = (w_chunk == w_base_rem);
      w_cur_addr_nxt  = w_base_addr + ADDR_W'(w_chunk);
      w_remaining_nxt = w_base_rem - w_chunk;
    end

    w_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  always_ff @(posedge user_clk or posedge user_areset) begin
    if (user_areset) begin
      r_state     <= ST_IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_ready     <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_addr    <= '0;
      r_m_len     <= '0;
      r_m_last    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_addr  <= w_cur_addr_nxt;
      r_remaining <= w_remaining_nxt;
      r_ready     <= w_ready_nxt;
      r_m_valid   <= w_m_valid_nxt;
      r_m_addr    <= w_m_addr_nxt;
      r_m_len     <= w_m_len_nxt;
      r_m_last    <= w_m_last_nxt;
    end
  end

  assign s_axis_cmd_ready   = r_ready;
  assign m_axis_cmd_valid   = r_m_valid;
  assign m_axis_cmd_address = r_m_addr;
  assign m_axis_cmd_length  = r_m_len;
  assign m_axis_cmd_last    = r_m_last;

`ifdef MEM_CMD_SPLITTER_STATS_EN
  logic [31:0] r_stat_in, r_stat_out;

  always_ff @(posedge user_clk or posedge user_areset) begin
    if (user_areset) begin
      r_stat_in  <= '0;
      r_stat_out <= '0;
    end else begin
      if (w_in_hs && (r_stat_in != '1))
        r_stat_in <= r_stat_in + 32'd1;
      if (w_out_hs && (r_stat_out != '1))
        r_stat_out <= r_stat_out + 32'd1;
    end
  end

  assign stat_in_cmds  = r_stat_in;
  assign stat_out_cmds = r_stat_out;
`endif

endmodule

`default_nettype wire
